// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and defaults for the register-bank arbiter.
// Contents: FSM state encoding, request payload struct, default
// parameter values and a small modulo-increment helper.
package reg_bank_arbiter_pkg;

    localparam int unsigned ARB_NUM_REQ = 2;
    localparam int unsigned ARB_ADDR_W  = 8;
    localparam int unsigned ARB_DATA_W  = 8;
    localparam int unsigned ARB_RD_LAT  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic                  write;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } reg_req_t;

    // (idx + 1) mod n, written without a divider
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_grant.sv
// Combinational requester pick for reg_bank_arbiter.
// Default build: round-robin, search starts at rr_ptr and wraps.
// With ARB_STRICT_PRIO_EN defined: fixed priority, lowest index wins,
// rr_ptr is ignored.
// Ports:
//   req     - pending request vector
//   rr_ptr  - round-robin search start index
//   grant_c - one-hot winner
//   idx_c   - encoded winner index
//   any_c   - at least one request pending
module reg_bank_arbiter_rr_grant
    import reg_bank_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = ARB_NUM_REQ,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               any_c
);

`ifdef ARB_STRICT_PRIO_EN
    logic unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr;
`endif

    logic [IDX_W-1:0] cand;

    // Walk candidates in search order; the first pending one wins
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef ARB_STRICT_PRIO_EN
            cand = IDX_W'(k);
`else
            cand = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
`endif
            if (!any_c && req[cand]) begin
                any_c         = 1'b1;
                grant_c[cand] = 1'b1;
                idx_c         = cand;
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Shares one register_bank port between NUM_REQ requesters.
// One transaction at a time: accept, issue one bank strobe, wait the
// bank read latency, return a completion pulse with read data.
// Build option: ARB_STRICT_PRIO_EN selects fixed priority (req 0 wins)
// instead of round-robin; ports and timing are identical.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/write/addr/wdata - per-requester command (packed buses)
//   req_ready             - one-hot accept pulse
//   rsp_valid, rsp_rdata  - one-hot completion pulse, shared read data
//   mem_write_en/read_en/addr/write_data, mem_read_data - bank port
//   busy                  - arbiter not IDLE
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = ARB_NUM_REQ,
    parameter int unsigned ADDR_W  = ARB_ADDR_W,
    parameter int unsigned DATA_W  = ARB_DATA_W,
    parameter int unsigned RD_LAT  = ARB_RD_LAT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        mem_write_en,
    output logic                        mem_read_en,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_write_data,
    input  logic [DATA_W-1:0]           mem_read_data,
    output logic                        busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic                write_q, write_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                mem_write_en_q, mem_write_en_d;
    logic                mem_read_en_q, mem_read_en_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_write_data_q, mem_write_data_d;
    logic                busy_q, busy_d;
    logic [IDX_W-1:0]    ptr_c;

`ifndef ARB_STRICT_PRIO_EN
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    assign ptr_c = rr_ptr_q;
`else
    assign ptr_c = '0;
`endif

    logic [NUM_REQ-1:0]  grant_c;
    logic [IDX_W-1:0]    idx_c;
    logic                any_c;

    // Unpack per-requester address/data for indexed selection
    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    reg_bank_arbiter_rr_grant #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_grant (
        .req     (req_valid),
        .rr_ptr  (ptr_c),
        .grant_c (grant_c),
        .idx_c   (idx_c),
        .any_c   (any_c)
    );

    // Next state and registered outputs; outputs take effect in the
    // state being entered, so mem strobes appear during ISSUE
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        write_d          = write_q;
        lat_cnt_d        = lat_cnt_q;
        req_ready_d      = '0;
        rsp_valid_d      = '0;
        rsp_rdata_d      = rsp_rdata_q;
        mem_write_en_d   = 1'b0;
        mem_read_en_d    = 1'b0;
        mem_addr_d       = '0;
        mem_write_data_d = '0;
`ifndef ARB_STRICT_PRIO_EN
        rr_ptr_d         = rr_ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (any_c) begin
                    owner_d          = idx_c;
                    write_d          = req_write[idx_c];
                    req_ready_d      = grant_c;
                    mem_write_en_d   = req_write[idx_c];
                    mem_read_en_d    = !req_write[idx_c];
                    mem_addr_d       = addr_arr[idx_c];
                    mem_write_data_d = wdata_arr[idx_c];
                    state_d          = ISSUE;
                end
            end
            ISSUE: begin
                if (write_q) begin
                    state_d = RESP;
                end else begin
                    lat_cnt_d = LAT_W'(RD_LAT - 1);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    rsp_rdata_d = mem_read_data;
                    state_d     = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                rsp_valid_d = NUM_REQ'(1) << owner_q;
                if (write_q) begin
                    rsp_rdata_d = '0;
                end
`ifndef ARB_STRICT_PRIO_EN
                rr_ptr_d = IDX_W'(next_idx(32'(owner_q), NUM_REQ));
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            owner_q          <= '0;
            write_q          <= 1'b0;
            lat_cnt_q        <= '0;
            req_ready_q      <= '0;
            rsp_valid_q      <= '0;
            rsp_rdata_q      <= '0;
            mem_write_en_q   <= 1'b0;
            mem_read_en_q    <= 1'b0;
            mem_addr_q       <= '0;
            mem_write_data_q <= '0;
            busy_q           <= 1'b0;
`ifndef ARB_STRICT_PRIO_EN
            rr_ptr_q         <= '0;
`endif
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            write_q          <= write_d;
            lat_cnt_q        <= lat_cnt_d;
            req_ready_q      <= req_ready_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_rdata_q      <= rsp_rdata_d;
            mem_write_en_q   <= mem_write_en_d;
            mem_read_en_q    <= mem_read_en_d;
            mem_addr_q       <= mem_addr_d;
            mem_write_data_q <= mem_write_data_d;
            busy_q           <= busy_d;
`ifndef ARB_STRICT_PRIO_EN
            rr_ptr_q         <= rr_ptr_d;
`endif
        end
    end

    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign mem_write_en   = mem_write_en_q;
    assign mem_read_en    = mem_read_en_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_write_data_q;
    assign busy           = busy_q;

endmodule
